// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for register-bank write arbiters.
package reg_bank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;
  localparam int MAX_ONEHOT = 256;

  // Returns a one-hot vector with bit addr set, or all zeros when addr >= n.
  function automatic logic [MAX_ONEHOT-1:0] onehot_decode(input int unsigned addr,
                                                          input int unsigned n);
    logic [MAX_ONEHOT-1:0] v;
    v = '0;
    if (addr < n && addr < MAX_ONEHOT) v[addr[7:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester/bank-side bus of the register write arbiter.
interface reg_write_arbiter_if
  import reg_bank_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REGS-1:0]       wr_en;
  logic [DATA_W-1:0]         wr_data;
  logic                      addr_err;
  logic                      busy;

  modport master (
    output req, req_addr, req_data,
    input  gnt, wr_en, wr_data, addr_err, busy
  );

  modport slave (
    input  req, req_addr, req_data,
    output gnt, wr_en, wr_data, addr_err, busy
  );
endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or after ptr, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] win,
  output logic             found
);
  logic [PTR_W-1:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    // Scan farthest-first so the nearest eligible index after ptr is written last.
    for (int k = N - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (eligible[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter feeding a shared register bank, one registered write per cycle.
// Define REQ0_PRIORITY_EN to give requester 0 fixed priority over the rotating others.
module reg_write_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input logic               Clk,
  input logic               Reset,
  reg_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  state_t              state_reg, state_next;
  logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0]    last_win_reg;
  logic                last_win_valid_reg;
  logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
  logic [NUM_REGS-1:0] wr_en_reg, wr_en_next;
  logic [DATA_W-1:0]   wr_data_reg, wr_data_next;
  logic                addr_err_reg, addr_err_next;

  logic [NUM_REQ-1:0]  eligible, pick_set;
  logic [PTR_W-1:0]    rr_win, win;
  logic                rr_found, found;

  // The previous winner only learns of its grant at this edge, so its req is still up.
  assign eligible = bus.req & ~(last_win_valid_reg ?
                                NUM_REQ'(onehot_decode(32'(last_win_reg), NUM_REQ)) : '0);

`ifdef REQ0_PRIORITY_EN
  assign pick_set = {eligible[NUM_REQ-1:1], 1'b0};
`else
  assign pick_set = eligible;
`endif

  rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .eligible(pick_set),
    .ptr     (rr_ptr_reg),
    .win     (rr_win),
    .found   (rr_found)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg          <= IDLE;
      rr_ptr_reg         <= '0;
      last_win_reg       <= '0;
      last_win_valid_reg <= 1'b0;
      gnt_reg            <= '0;
      wr_en_reg          <= '0;
      wr_data_reg        <= '0;
      addr_err_reg       <= 1'b0;
    end else begin
      state_reg          <= state_next;
      rr_ptr_reg         <= rr_ptr_next;
      last_win_reg       <= win;
      last_win_valid_reg <= found;
      gnt_reg            <= gnt_next;
      wr_en_reg          <= wr_en_next;
      wr_data_reg        <= wr_data_next;
      addr_err_reg       <= addr_err_next;
    end
  end

  always_comb begin
    win         = rr_win;
    found       = rr_found;
    state_next  = IDLE;
    rr_ptr_next = rr_ptr_reg;
`ifdef REQ0_PRIORITY_EN
    if (eligible[0]) begin
      win   = '0;
      found = 1'b1;
    end
`endif
    if (found) begin
      state_next = GRANT;
      if (int'(win) == NUM_REQ - 1) rr_ptr_next = '0;
      else                          rr_ptr_next = win + PTR_W'(1);
`ifdef REQ0_PRIORITY_EN
      if (eligible[0]) rr_ptr_next = rr_ptr_reg;
`endif
    end
  end

  always_comb begin
    gnt_next      = '0;
    wr_en_next    = '0;
    addr_err_next = 1'b0;
    wr_data_next  = wr_data_reg;
    if (found) begin
      gnt_next      = NUM_REQ'(onehot_decode(32'(win), NUM_REQ));
      wr_en_next    = NUM_REGS'(onehot_decode(32'(addr_arr[win]), NUM_REGS));
      addr_err_next = (32'(addr_arr[win]) >= NUM_REGS);
      wr_data_next  = data_arr[win];
    end
  end

  assign bus.gnt      = gnt_reg;
  assign bus.wr_en    = wr_en_reg;
  assign bus.wr_data  = wr_data_reg;
  assign bus.addr_err = addr_err_reg;
  assign bus.busy     = (state_reg == GRANT);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Table-driven bench for reg_write_arbiter with a 6-entry register bank model.
module tb_reg_write_arbiter;
  logic Clk;
  logic Reset;
  logic bank_clr;
  logic [31:0] bank [6];
  int total;
  int bad;

  reg_write_arbiter_if #(.NUM_REQ(4), .NUM_REGS(6), .ADDR_W(3), .DATA_W(32)) bus ();

  reg_write_arbiter #(.NUM_REQ(4), .NUM_REGS(6), .ADDR_W(3), .DATA_W(32)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    for (int k = 0; k < 6; k++) begin
      if (bank_clr) bank[k] <= '0;
      else if (bus.wr_en[k]) bank[k] <= bus.wr_data;
    end
  end

  typedef struct {
    logic [3:0]   req;
    logic [11:0]  addr;
    logic [127:0] data;
    logic [3:0]   gnt;
    logic [5:0]   wr_en;
    logic         err;
    logic         busy;
    logic [31:0]  wdata;
  } vec_t;

  vec_t vecs[16];
  int   nvec;

  function automatic vec_t mk(input logic [3:0] r, input logic [11:0] a, input logic [127:0] d,
                              input logic [3:0] g, input logic [5:0] w, input logic e,
                              input logic b, input logic [31:0] wd);
    vec_t v;
    v.req = r; v.addr = a; v.data = d; v.gnt = g; v.wr_en = w;
    v.err = e; v.busy = b; v.wdata = wd;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  localparam logic [11:0]  AD  = 12'h688;
  localparam logic [127:0] D   = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [127:0] D2  = 128'h000000A3_000000C2_000000A1_000000A0;
  localparam logic [127:0] D3  = 128'h000000A3_000000C2_DEADBEEF_000000A0;
  localparam logic [127:0] D4  = 128'h00000055_000000C2_DEADBEEF_000000A0;
  localparam logic [127:0] D5  = 128'h000000A3_000000A2_55555555_000000A0;

  initial begin
    total = 0;
    bad = 0;
    Clk = 0;
    Reset = 1;
    bank_clr = 1;
    bus.req = 4'b1111;
    bus.req_addr = AD;
    bus.req_data = D;
    #2 Reset = 0;

`ifndef REQ0_PRIORITY_EN
    vecs[0]  = mk(4'b1111, AD,     D,  4'b0001, 6'b000001, 0, 1, 32'hA0);
    vecs[1]  = mk(4'b1111, AD,     D,  4'b0010, 6'b000010, 0, 1, 32'hA1);
    vecs[2]  = mk(4'b1111, AD,     D,  4'b0100, 6'b000100, 0, 1, 32'hA2);
    vecs[3]  = mk(4'b1111, AD,     D,  4'b1000, 6'b001000, 0, 1, 32'hA3);
    vecs[4]  = mk(4'b1111, AD,     D,  4'b0001, 6'b000001, 0, 1, 32'hA0);
    vecs[5]  = mk(4'b0000, AD,     D,  4'b0000, 6'b000000, 0, 0, 32'hA0);
    vecs[6]  = mk(4'b0100, 12'h708, D2, 4'b0100, 6'b010000, 0, 1, 32'hC2);
    vecs[7]  = mk(4'b0100, 12'h708, D2, 4'b0000, 6'b000000, 0, 0, 32'hC2);
    vecs[8]  = mk(4'b0100, 12'h708, D2, 4'b0100, 6'b010000, 0, 1, 32'hC2);
    vecs[9]  = mk(4'b0100, 12'h708, D2, 4'b0000, 6'b000000, 0, 0, 32'hC2);
    vecs[10] = mk(4'b0010, 12'h738, D3, 4'b0010, 6'b000000, 1, 1, 32'hDEADBEEF);
    vecs[11] = mk(4'b0000, 12'h738, D3, 4'b0000, 6'b000000, 0, 0, 32'hDEADBEEF);
    vecs[12] = mk(4'b1000, 12'hB38, D4, 4'b1000, 6'b100000, 0, 1, 32'h55);
    vecs[13] = mk(4'b1001, 12'hB38, D4, 4'b0001, 6'b000001, 0, 1, 32'hA0);
    vecs[14] = mk(4'b1001, 12'hB38, D4, 4'b1000, 6'b100000, 0, 1, 32'h55);
    vecs[15] = mk(4'b0000, 12'hB38, D4, 4'b0000, 6'b000000, 0, 0, 32'h55);
    nvec = 16;
`else
    vecs[0]  = mk(4'b1111, AD, D, 4'b0001, 6'b000001, 0, 1, 32'hA0);
    vecs[1]  = mk(4'b1110, AD, D, 4'b0010, 6'b000010, 0, 1, 32'hA1);
    vecs[2]  = mk(4'b1110, AD, D, 4'b0100, 6'b000100, 0, 1, 32'hA2);
    vecs[3]  = mk(4'b1111, AD, D, 4'b0001, 6'b000001, 0, 1, 32'hA0);
    vecs[4]  = mk(4'b1111, AD, D, 4'b1000, 6'b001000, 0, 1, 32'hA3);
    vecs[5]  = mk(4'b0000, AD, D, 4'b0000, 6'b000000, 0, 0, 32'hA3);
    nvec = 6;
`endif

    // Reset held with all requests up: nothing may be granted.
    step();
    step();
    check("rst gnt", 128'(bus.gnt), 128'h0);
    check("rst wr_en", 128'(bus.wr_en), 128'h0);
    check("rst busy", 128'(bus.busy), 128'h0);
    check("rst addr_err", 128'(bus.addr_err), 128'h0);
    check("rst wr_data", 128'(bus.wr_data), 128'h0);
    Reset = 1;
    bank_clr = 0;

    for (int i = 0; i < nvec; i++) begin
      bus.req = vecs[i].req;
      bus.req_addr = vecs[i].addr;
      bus.req_data = vecs[i].data;
      step();
      check($sformatf("v%0d gnt", i), 128'(bus.gnt), 128'(vecs[i].gnt));
      check($sformatf("v%0d wr_en", i), 128'(bus.wr_en), 128'(vecs[i].wr_en));
      check($sformatf("v%0d addr_err", i), 128'(bus.addr_err), 128'(vecs[i].err));
      check($sformatf("v%0d busy", i), 128'(bus.busy), 128'(vecs[i].busy));
      check($sformatf("v%0d wr_data", i), 128'(bus.wr_data), 128'(vecs[i].wdata));
    end

`ifndef REQ0_PRIORITY_EN
    check("bank0", 128'(bank[0]), 128'hA0);
    check("bank1", 128'(bank[1]), 128'hA1);
    check("bank2", 128'(bank[2]), 128'hA2);
    check("bank3", 128'(bank[3]), 128'hA3);
    check("bank4", 128'(bank[4]), 128'hC2);
    check("bank5", 128'(bank[5]), 128'h55);
`endif

    // Reset falls mid-grant: the write to register 1 must never land.
    bus.req = 4'b0000;
    step();
    bus.req = 4'b0010;
    bus.req_addr = AD;
    bus.req_data = D5;
    step();
    check("mid gnt", 128'(bus.gnt), 128'h2);
    check("mid wr_en", 128'(bus.wr_en), 128'h2);
    check("mid wr_data", 128'(bus.wr_data), 128'h55555555);
    #3 Reset = 0;
    #1;
    check("mid rst gnt", 128'(bus.gnt), 128'h0);
    check("mid rst wr_en", 128'(bus.wr_en), 128'h0);
    check("mid rst busy", 128'(bus.busy), 128'h0);
    check("mid rst wr_data", 128'(bus.wr_data), 128'h0);
    bus.req = 4'b0000;
    step();
    check("mid bank1 kept", 128'(bank[1]), 128'hA1);
    Reset = 1;
    bus.req = 4'b1111;
    bus.req_data = D;
    step();
    check("restart gnt", 128'(bus.gnt), 128'h1);
    check("restart wr_en", 128'(bus.wr_en), 128'h1);
    bus.req = 4'b0000;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares a bank of NUM_REGS 32-bit registers (Register32 instances, Wr/Data_in driven by this block) among NUM_REQ requesters.
- Arbitrates write requests round-robin and issues one registered write per cycle.
- Each write drives exactly one register's Wr enable plus the common write-data bus.
- Sits between requester logic and the register bank; the registers themselves stay outside this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- NUM_REGS, 8, number of registers in the bank
- ADDR_W, 3, register address width; must satisfy 2**ADDR_W >= NUM_REGS
- DATA_W, 32, data width

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req  in  NUM_REQ  per-requester write request, level; held until gnt seen
- req_addr  in  NUM_REQ*ADDR_W  packed target addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W]
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
- wr_en  out  NUM_REGS  one-hot Wr enables to the register bank
- wr_data  out  DATA_W  common Data_in to the register bank
- addr_err  out  1  one-cycle pulse: the granted address was >= NUM_REGS
- busy  out  1  high while in state GRANT

Behaviour:
- Reset low, asynchronously:
  - gnt=0, wr_en=0, wr_data=0, addr_err=0, busy=0
  - state=IDLE, rr_ptr=0, last_win_valid=0
- FSM has two states, IDLE and GRANT.
- Each rising edge, the eligible set is req with the last winner's bit masked:
  - The mask applies only for the edge that ends that winner's GRANT cycle.
  - Reason: a requester first sees its gnt at that edge, so it cannot have dropped req yet.
- If the eligible set is non-empty, pick the winner:
  - Search starts at rr_ptr and wraps modulo NUM_REQ; first set bit wins.
  - Register gnt[win]=1 and wr_data=req_data[win].
  - Register wr_en[req_addr[win]]=1 when the address is < NUM_REGS; otherwise wr_en=0 and addr_err=1.
  - Set rr_ptr=(win+1) mod NUM_REQ, state=GRANT, busy=1.
- If the eligible set is empty: gnt=0, wr_en=0, addr_err=0, state=IDLE, busy=0. wr_data holds its last value.
- GRANT to GRANT: back-to-back grants to different requesters are allowed, giving one write per cycle of throughput.
- A requester holding req across two grants is served at most every other cycle (because of the mask).
- Latency:
  - req sampled at edge N.
  - gnt, wr_en and wr_data valid during cycle N..N+1.
  - The register captures at edge N+1.
  - Data_out of the register reflects the new data after edge N+1.
- The requester samples gnt at edge N+1 and must deassert req or present its next request by then.
- Simultaneous requests to the same address: round-robin order decides; the later grant overwrites.
- Reset asserted mid-GRANT: gnt and wr_en drop immediately (asynchronously); the in-flight write is lost only if Reset falls before the capturing edge.
- req, req_addr and req_data are sampled only at the edge; glitches between edges are ignored.
- The arbiter never asserts more than one gnt bit or more than one wr_en bit.

Optional Feature:
- Macro: REQ0_PRIORITY_EN.
- Defined:
  - Requester 0 wins whenever it is eligible, regardless of rr_ptr.
  - rr_ptr is not updated on a requester-0 win.
  - Requesters 1..NUM_REQ-1 rotate round-robin among themselves.
  - The last-winner mask still applies to requester 0.
- Undefined: pure round-robin over all requesters as above.

Decomposition:
- Shared package reg_bank_pkg:
  - state enum {IDLE, GRANT}
  - DATA_W and ADDR_W defaults
  - function onehot_decode(addr, n)
- One natural sub-module: rr_pick, combinational.
  - Inputs: eligible vector and rr_ptr.
  - Outputs: winner index and a found flag.
  - Reused by future bus arbiters.

Test Plan:
- Reset low, all req=1 → gnt=0, wr_en=0, busy=0. Reset high, then first edge → gnt=4'b0001, wr_en per req_addr[0].
- req=4'b1111 held, addrs 0..3, data 32'hA0..A3 → grants in order 0,1,2,3,0… one per cycle. Register k holds 32'hA0+k after its grant edge.
- Only req[2]=1, held 4 cycles → gnt[2] pulses on alternate cycles (mask). busy toggles 1,0,1,0.
- req[1]=1, addr=3'd7, NUM_REGS=6 → gnt[1]=1, wr_en=0, addr_err=1 for one cycle. The bank is unchanged.
- Reset pulled low midway through a GRANT cycle with wr_data=32'h55555555 → wr_en and gnt drop within the same cycle. The target register keeps its old value. After release, arbitration restarts at requester 0.
- With REQ0_PRIORITY_EN, req=4'b1111, req[0] dropped after its grant → order 0,1,2,3. req[0] reasserted during requester 2's grant → requester 0 wins at the next edge.
